// File: rtl/dadda_pkg.sv
// Shared definitions for the Dadda product accumulator.
// Holds the accumulator FSM state encoding and the default datapath widths.
package dadda_pkg;

    localparam int unsigned DADDA_PROD_W = 16;
    localparam int unsigned DADDA_ACC_W  = 24;
    localparam int unsigned DADDA_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } dadda_state_e;

endpackage

// File: rtl/dadda_acc_add.sv
// Combinational ACC_W-bit unsigned adder with carry out.
// Ports: a, b  - addends
//        sum   - low ACC_W bits of a + b
//        cout  - carry out of bit ACC_W-1
module dadda_acc_add #(
    parameter int unsigned ACC_W = 24
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             cout
);

    localparam int unsigned SUM_W = ACC_W + 1;

    assign {cout, sum} = SUM_W'(a) + SUM_W'(b);

endmodule

// File: rtl/dadda_prod_acc.sv
// Accumulate stage behind the 8x8 Dadda multiplier: sums a programmed run of
// len products and presents the total on a valid/ready output port.
// Ports: clk, rst (async, active-high)
//        start/len    - launch a run of len products (sampled in IDLE only)
//        clear        - synchronous abort back to IDLE, highest priority
//        prod_valid/prod_ready/prod_data - product input handshake
//        out_valid/out_ready/out_data/out_ovf - result output handshake
//        busy         - state is not IDLE
// Build option: DADDA_ACC_SAT_EN selects saturating accumulation with an
// overflow flag; otherwise the accumulator wraps and out_ovf stays 0.
module dadda_prod_acc
    import dadda_pkg::*;
#(
    parameter int unsigned PROD_W = DADDA_PROD_W,
    parameter int unsigned ACC_W  = DADDA_ACC_W,
    parameter int unsigned CNT_W  = DADDA_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              clear,
    input  logic              prod_valid,
    output logic              prod_ready,
    input  logic [PROD_W-1:0] prod_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    dadda_state_e     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             prod_ready_q, prod_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic             accept;

    dadda_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .a    (acc_q),
        .b    (ACC_W'(prod_data)),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifndef DADDA_ACC_SAT_EN
    logic unused_add_cout;
    assign unused_add_cout = add_cout;
`endif

    // prod_ready_q is only high in ACC, so this is the ACC-state accept
    assign accept = prod_valid && prod_ready_q;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        if (clear) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                        if (len != '0) begin
                            state_d = ST_ACC;
                            cnt_d   = len;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        cnt_d = cnt_q - CNT_W'(1);
`ifdef DADDA_ACC_SAT_EN
                        // once clamped, the rest of the run is ignored
                        if (!ovf_q) begin
                            if (add_cout) begin
                                acc_d = '1;
                                ovf_d = 1'b1;
                            end else begin
                                acc_d = add_sum;
                            end
                        end
`else
                        acc_d = add_sum;
`endif
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // handshake flags follow the next state so they are pure flops
        prod_ready_d = (state_d == ST_ACC);
        out_valid_d  = (state_d == ST_HOLD);
        busy_d       = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            prod_ready_q <= prod_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = acc_q;
    assign out_ovf    = ovf_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dadda_prod_acc.sv
// Self-checking bench for dadda_prod_acc: directed scenarios plus randomized
// runs against a sum-of-products reference model. A second instance with a
// 17-bit accumulator covers overflow behaviour (DADDA_ACC_SAT_EN aware).
module tb_dadda_prod_acc;

    localparam int unsigned OVF_W   = 17;
    localparam longint      OVF_MAX = (longint'(1) << OVF_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        clear;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic        out_ready;

    logic        prod_ready, out_valid, out_ovf, busy;
    logic [23:0] out_data;
    logic        o_prod_ready, o_out_valid, o_out_ovf, o_busy;
    logic [16:0] o_out_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dadda_prod_acc u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(prod_ready), .prod_data(prod_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    dadda_prod_acc #(.ACC_W(OVF_W)) u_ovf (
        .clk(clk), .rst(rst), .start(start), .len(len), .clear(clear),
        .prod_valid(prod_valid), .prod_ready(o_prod_ready), .prod_data(prod_data),
        .out_valid(o_out_valid), .out_ready(out_ready), .out_data(o_out_data),
        .out_ovf(o_out_ovf), .busy(o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected narrow-accumulator result for a true (unbounded) sum
    function automatic longint ovf_ref_data(input longint total);
`ifdef DADDA_ACC_SAT_EN
        return (total > OVF_MAX) ? OVF_MAX : total;
`else
        return total % (OVF_MAX + 1);
`endif
    endfunction

    function automatic logic ovf_ref_flag(input longint total);
`ifdef DADDA_ACC_SAT_EN
        return total > OVF_MAX;
`else
        return (total < 0);
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; clear = 1'b0;
        prod_valid = 1'b0; prod_data = '0; out_ready = 1'b0;
        tick(); tick();
        n_chk++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL reset_prod_ready: got %0b want 0", prod_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_chk++; if (out_data !== 24'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
        n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %0b want 0", out_ovf); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        rst = 1'b0;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_after: busy got %0b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [15:0] prods [3];
        prods[0] = 16'd225; prods[1] = 16'd100; prods[2] = 16'd1;
        out_ready = 1'b1;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        n_chk++; if (prod_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_start: got %0b want 1", prod_ready); end
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1; prod_data = prods[i];
            tick();
        end
        prod_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b want 1", out_valid); end
        n_chk++; if (out_data !== 24'd326) begin n_fail++; $display("FAIL basic_out_data: got %0d want 326", out_data); end
        n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_out_ovf: got %0b want 0", out_ovf); end
        n_chk++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_hold: got %0b want 0", prod_ready); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_latency: busy got %0b want 0", busy); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [15:0] a, b;
        a = 16'($urandom_range(255) * $urandom_range(255));
        b = 16'($urandom_range(255) * $urandom_range(255));
        out_ready = 1'b0;
        start = 1'b1; len = 8'd2;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = a;
        tick();
        prod_valid = 1'b0; prod_data = 16'hFFFF;
        for (int g = 0; g < 3; g++) begin
            n_chk++; if (prod_ready !== 1'b1) begin n_fail++; $display("FAIL stall_gap_ready: cycle %0d got %0b want 1", g, prod_ready); end
            tick();
        end
        prod_valid = 1'b1; prod_data = b;
        tick();
        prod_data = 16'd999;
        for (int s = 0; s < 4; s++) begin
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: cycle %0d got %0b want 1", s, out_valid); end
            n_chk++; if (out_data !== 24'(32'(a) + 32'(b))) begin n_fail++; $display("FAIL stall_data: cycle %0d got %0d want %0d", s, out_data, 32'(a) + 32'(b)); end
            n_chk++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_hold: cycle %0d got %0b want 0", s, prod_ready); end
            tick();
        end
        prod_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_release: busy got %0b want 0", busy); end
    endtask

    task automatic test_zero_len();
        out_ready = 1'b0;
        prod_valid = 1'b1; prod_data = 16'd55;
        start = 1'b1; len = 8'd0;
        tick();
        start = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %0b want 1", out_valid); end
        n_chk++; if (out_data !== 24'd0) begin n_fail++; $display("FAIL zero_data: got %0d want 0", out_data); end
        n_chk++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL zero_ready: got %0b want 0", prod_ready); end
        tick();
        n_chk++; if (out_data !== 24'd0) begin n_fail++; $display("FAIL zero_no_accept: got %0d want 0", out_data); end
        prod_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_release: busy got %0b want 0", busy); end
    endtask

    task automatic test_clear_and_reset();
        out_ready = 1'b1;
        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_data = 16'd40;
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0; prod_valid = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_idle: busy got %0b want 0", busy); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_no_valid: got %0b want 0", out_valid); end
        n_chk++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %0b want 0", prod_ready); end
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_still_no_valid: got %0b want 0", out_valid); end
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod_data = 16'd7;
        tick();
        prod_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clear_rerun_valid: got %0b want 1", out_valid); end
        n_chk++; if (out_data !== 24'd7) begin n_fail++; $display("FAIL clear_rerun_data: got %0d want 7", out_data); end
        tick();

        start = 1'b1; len = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1'b1; prod_data = 16'd123;
            tick();
        end
        prod_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b want 0", busy); end
        n_chk++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %0b want 0", prod_ready); end
        n_chk++; if (out_data !== 24'd0) begin n_fail++; $display("FAIL arst_data: got %0d want 0", out_data); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b want 0", out_valid); end
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_output: got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        longint total;
        total = 0;
        out_ready = 1'b0;
        start = 1'b1; len = 8'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            prod_valid = 1'b1; prod_data = 16'd65025;
            total += 65025;
            tick();
        end
        prod_valid = 1'b0;
        n_chk++; if (o_out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %0b want 1", o_out_valid); end
        n_chk++; if (longint'(o_out_data) !== ovf_ref_data(total)) begin n_fail++; $display("FAIL ovf_data: got %0d want %0d", o_out_data, ovf_ref_data(total)); end
        n_chk++; if (o_out_ovf !== ovf_ref_flag(total)) begin n_fail++; $display("FAIL ovf_flag: got %0b want %0b", o_out_ovf, ovf_ref_flag(total)); end
        n_chk++; if (out_data !== 24'd195075) begin n_fail++; $display("FAIL ovf_wide_data: got %0d want 195075", out_data); end
        n_chk++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_wide_flag: got %0b want 0", out_ovf); end
        tick();
        n_chk++; if (o_out_ovf !== ovf_ref_flag(total)) begin n_fail++; $display("FAIL ovf_flag_stall: got %0b want %0b", o_out_ovf, ovf_ref_flag(total)); end
        out_ready = 1'b1;
        tick();
        n_chk++; if (o_out_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_cleared: got %0b want 0", o_out_ovf); end
        n_chk++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_release: busy got %0b want 0", o_busy); end
    endtask

    task automatic test_ignored_events();
        out_ready = 1'b0;
        start = 1'b1; len = 8'd2;
        tick();
        len = 8'd7;
        prod_valid = 1'b1; prod_data = 16'd10;
        tick();
        prod_data = 16'd20;
        tick();
        start = 1'b0; prod_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ignored_start_len: out_valid got %0b want 1", out_valid); end
        n_chk++; if (out_data !== 24'd30) begin n_fail++; $display("FAIL ignored_start_data: got %0d want 30", out_data); end
        clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_vs_ready_busy: got %0b want 0", busy); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_vs_ready_valid: got %0b want 0", out_valid); end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_no_restart: busy got %0b want 0", busy); end
    endtask

    task automatic test_random_runs();
        for (int run = 0; run < 12; run++) begin
            int unsigned L;
            int unsigned got;
            int unsigned stall;
            longint total;
            logic [15:0] d;
            L = $urandom_range(1, 8);
            got = 0; total = 0;
            out_ready = 1'b0;
            start = 1'b1; len = 8'(L);
            tick();
            start = 1'b0;
            for (int cyc = 0; cyc < 200 && got < L; cyc++) begin
                len = 8'($urandom_range(255));
                d = 16'($urandom_range(255) * $urandom_range(255));
                prod_valid = 1'($urandom_range(1));
                prod_data = d;
                n_chk++; if (prod_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready: run %0d got %0b want 1", run, prod_ready); end
                if (prod_valid) begin
                    total += longint'(d);
                    got++;
                end
                tick();
            end
            prod_valid = 1'b0;
            n_chk++; if (got != L) begin n_fail++; $display("FAIL rand_timeout: run %0d accepted %0d want %0d", run, got, L); end
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= int'(stall); s++) begin
                prod_valid = 1'($urandom_range(1));
                n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid: run %0d got %0b want 1", run, out_valid); end
                n_chk++; if (longint'(out_data) !== total) begin n_fail++; $display("FAIL rand_data: run %0d got %0d want %0d", run, out_data, total); end
                n_chk++; if (longint'(o_out_data) !== ovf_ref_data(total)) begin n_fail++; $display("FAIL rand_narrow_data: run %0d got %0d want %0d", run, o_out_data, ovf_ref_data(total)); end
                n_chk++; if (o_out_ovf !== ovf_ref_flag(total)) begin n_fail++; $display("FAIL rand_narrow_ovf: run %0d got %0b want %0b", run, o_out_ovf, ovf_ref_flag(total)); end
                if (s == int'(stall)) out_ready = 1'b1;
                tick();
            end
            prod_valid = 1'b0;
            n_chk++; if (busy !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL rand_release: run %0d busy %0b/%0b want 0/0", run, busy, o_busy); end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_clear_and_reset();
        test_overflow();
        test_ignored_events();
        test_random_runs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
